// File: rtl/spart_pkg.sv
// Shared definitions for the SPART bus-master driver: FSM states, bus
// address/direction encodings and the default baud divisors.
package spart_pkg;

    typedef enum logic [2:0] {
        LOAD_LO,
        LOAD_HI,
        IDLE,
        READ,
        WAIT_TBR,
        WRITE
    } state_t;

    localparam logic [1:0] ADDR_DATA   = 2'b00;
    localparam logic [1:0] ADDR_STATUS = 2'b01;
    localparam logic [1:0] ADDR_DBL    = 2'b10;
    localparam logic [1:0] ADDR_DBH    = 2'b11;

    localparam logic IORW_READ  = 1'b1;
    localparam logic IORW_WRITE = 1'b0;

    // 100 MHz clock, 16x oversampling
    localparam logic [15:0] DEF_DIV_4800  = 16'h0516;
    localparam logic [15:0] DEF_DIV_9600  = 16'h028B;
    localparam logic [15:0] DEF_DIV_19200 = 16'h0146;
    localparam logic [15:0] DEF_DIV_38400 = 16'h00A3;

endpackage

// File: rtl/spart_driver.sv
// Processor stand-in for the SPART: programs the baud divisor, then echoes
// every received byte back out. All bus outputs are registered.
module spart_driver
    import spart_pkg::*;
#(
    parameter logic [15:0] DIV_4800  = DEF_DIV_4800,
    parameter logic [15:0] DIV_9600  = DEF_DIV_9600,
    parameter logic [15:0] DIV_19200 = DEF_DIV_19200,
    parameter logic [15:0] DIV_38400 = DEF_DIV_38400
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] br_cfg,
    input  logic       rda,
    input  logic       tbr,
    output logic       iocs,
    output logic       iorw,
    output logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic [7:0] last_rx,
    output logic [7:0] echo_cnt
);

    state_t      r_state;
    state_t      w_nextState;
    logic [1:0]  r_brCfgQ;
    logic [1:0]  w_cfgSel;
    logic [15:0] w_div;

    logic        w_iocs;
    logic        w_iorw;
    logic [1:0]  w_addr;
    logic        w_oe;
    logic [7:0]  w_data;

    logic        r_iocs;
    logic        r_iorw;
    logic [1:0]  r_ioaddr;
    logic        r_oe;
    logic [7:0]  r_dataOut;
    logic [7:0]  r_lastRx;
    logic [7:0]  r_echoCnt;

    // br_cfg_q is captured on the LOAD_LO edge, so both divisor bytes use that value.
    assign w_cfgSel = (r_state == LOAD_LO) ? br_cfg : r_brCfgQ;

    always_comb begin
        case (w_cfgSel)
            2'b00:   w_div = DIV_4800;
            2'b01:   w_div = DIV_9600;
            2'b10:   w_div = DIV_19200;
            default: w_div = DIV_38400;
        endcase
    end

    always_comb begin
        w_nextState = r_state;
        w_iocs      = 1'b0;
        w_iorw      = IORW_READ;
        w_addr      = ADDR_DATA;
        w_oe        = 1'b0;
        w_data      = 8'h00;
        case (r_state)
            LOAD_LO: begin
                w_iocs      = 1'b1;
                w_iorw      = IORW_WRITE;
                w_addr      = ADDR_DBL;
                w_oe        = 1'b1;
                w_data      = w_div[7:0];
                w_nextState = LOAD_HI;
            end
            LOAD_HI: begin
                w_iocs      = 1'b1;
                w_iorw      = IORW_WRITE;
                w_addr      = ADDR_DBH;
                w_oe        = 1'b1;
                w_data      = w_div[15:8];
                w_nextState = IDLE;
            end
            IDLE: begin
                if (br_cfg != r_brCfgQ) begin
                    w_nextState = LOAD_LO;
                end else if (rda) begin
                    w_nextState = READ;
                end
            end
            READ: begin
                w_iocs      = 1'b1;
                w_iorw      = IORW_READ;
                w_addr      = ADDR_DATA;
                w_nextState = WAIT_TBR;
            end
            WAIT_TBR: begin
                if (tbr) begin
                    w_nextState = WRITE;
                end
            end
            WRITE: begin
                w_iocs      = 1'b1;
                w_iorw      = IORW_WRITE;
                w_addr      = ADDR_DATA;
                w_oe        = 1'b1;
                w_data      = r_lastRx;
                w_nextState = IDLE;
            end
            default: w_nextState = LOAD_LO;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= LOAD_LO;
            r_brCfgQ <= 2'b00;
        end else begin
            r_state <= w_nextState;
            if (r_state == LOAD_LO) begin
                r_brCfgQ <= br_cfg;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_iocs    <= 1'b0;
            r_iorw    <= IORW_READ;
            r_ioaddr  <= ADDR_DATA;
            r_oe      <= 1'b0;
            r_dataOut <= 8'h00;
        end else begin
            r_iocs    <= w_iocs;
            r_iorw    <= w_iorw;
            r_ioaddr  <= w_addr;
            r_oe      <= w_oe;
            r_dataOut <= w_data;
        end
    end

    // The read byte is sampled at the end of the cycle in which the read strobe is visible.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lastRx  <= 8'h00;
            r_echoCnt <= 8'h00;
        end else begin
            if (r_iocs && (r_iorw == IORW_READ)) begin
                r_lastRx <= databus;
            end
            if (r_state == WRITE) begin
                r_echoCnt <= r_echoCnt + 8'd1;
            end
        end
    end

    assign databus  = r_oe ? r_dataOut : 8'hzz;
    assign iocs     = r_iocs;
    assign iorw     = r_iorw;
    assign ioaddr   = r_ioaddr;
    assign last_rx  = r_lastRx;
    assign echo_cnt = r_echoCnt;

endmodule

// File: tb/tb_spart_driver.sv
// Self-checking bench for spart_driver: a transaction-level processor model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_spart_driver;

    typedef enum logic [2:0] {K_NONE, K_LO, K_HI, K_READ, K_WRITE} access_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] br_cfg = 2'b01;
    logic       rda = 1'b0;
    logic       tbr = 1'b1;
    logic [7:0] spartByte = 8'h00;

    // Pulled high so a released bus reads as all ones.
    tri1  [7:0] databus;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic [7:0] last_rx;
    logic [7:0] echo_cnt;

    int testsRun = 0;
    int testsFailed = 0;

    logic [15:0] divTable [4] = '{16'h0516, 16'h028B, 16'h0146, 16'h00A3};

    access_t    plan [$];
    access_t    expKind = K_NONE;
    access_t    modelCur = K_NONE;
    logic [7:0] expData = 8'h00;
    logic [7:0] expLastRx = 8'h00;
    logic [7:0] expCnt = 8'h00;
    logic [1:0] modelCfg = 2'b00;
    bit         needProg = 1'b1;
    bit         waitTbr = 1'b0;
    bit         rxLatch = 1'b0;
    logic       prevIocs = 1'b0;
    logic [1:0] prevAddr = 2'b00;

    spart_driver dut (
        .clk      (clk),
        .rst      (rst),
        .br_cfg   (br_cfg),
        .rda      (rda),
        .tbr      (tbr),
        .iocs     (iocs),
        .iorw     (iorw),
        .ioaddr   (ioaddr),
        .databus  (databus),
        .last_rx  (last_rx),
        .echo_cnt (echo_cnt)
    );

    always #5 clk = ~clk;

    assign databus = (iocs && iorw && ioaddr == 2'b00) ? spartByte : 8'hzz;

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rdaV, input logic tbrV, input logic [1:0] cfgV, input logic [7:0] byteV);
        rda       = rdaV;
        tbr       = tbrV;
        br_cfg    = cfgV;
        spartByte = byteV;
    endtask

    // Returns on the negedge where a data-register access in the wanted direction is visible.
    task automatic waitAccess(input logic wantRead, input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (iocs === 1'b1 && iorw === wantRead && ioaddr === 2'b00) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL %s: got no access within 40 cycles, expected one", name);
        end
    endtask

    task automatic doEcho(input logic [7:0] b);
        applyStimulus(1'b1, 1'b1, br_cfg, b);
        waitAccess(1'b1, "echoRead");
        rda = 1'b0;
        waitAccess(1'b0, "echoWrite");
    endtask

    // Processor-level model: one bus access per planned slot, decisions only when the plan is empty.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            plan.delete();
            expKind   = K_NONE;
            expLastRx = 8'h00;
            expCnt    = 8'h00;
            needProg  = 1'b1;
            waitTbr   = 1'b0;
            rxLatch   = 1'b0;
        end else begin
            modelCur = K_NONE;
            if (rxLatch) begin
                expLastRx = spartByte;
                rxLatch   = 1'b0;
            end
            if (plan.size() > 0) begin
                modelCur = plan.pop_front();
            end else if (waitTbr) begin
                if (tbr) begin
                    waitTbr = 1'b0;
                    plan.push_back(K_WRITE);
                end
            end else if (needProg) begin
                needProg = 1'b0;
                modelCur = K_LO;
                plan.push_back(K_HI);
            end else if (br_cfg != modelCfg) begin
                plan.push_back(K_LO);
                plan.push_back(K_HI);
            end else if (rda) begin
                plan.push_back(K_READ);
            end
            case (modelCur)
                K_LO: begin
                    modelCfg = br_cfg;
                    expData  = divTable[modelCfg][7:0];
                end
                K_HI:    expData = divTable[modelCfg][15:8];
                K_READ: begin
                    rxLatch = 1'b1;
                    waitTbr = 1'b1;
                end
                K_WRITE: begin
                    expData = expLastRx;
                    expCnt  = expCnt + 8'd1;
                end
                default: ;
            endcase
            expKind = modelCur;
        end
    end

    always @(negedge clk) begin
        checkOutput("iocs", 16'(iocs), 16'(expKind != K_NONE));
        case (expKind)
            K_LO: begin
                checkOutput("loAddr", 16'(ioaddr), 16'h0002);
                checkOutput("loIorw", 16'(iorw), 16'h0000);
                checkOutput("loData", 16'(databus), 16'(expData));
            end
            K_HI: begin
                checkOutput("hiAddr", 16'(ioaddr), 16'h0003);
                checkOutput("hiIorw", 16'(iorw), 16'h0000);
                checkOutput("hiData", 16'(databus), 16'(expData));
            end
            K_READ: begin
                checkOutput("rdAddr", 16'(ioaddr), 16'h0000);
                checkOutput("rdIorw", 16'(iorw), 16'h0001);
                checkOutput("rdBus", 16'(databus), 16'(spartByte));
            end
            K_WRITE: begin
                checkOutput("wrAddr", 16'(ioaddr), 16'h0000);
                checkOutput("wrIorw", 16'(iorw), 16'h0000);
                checkOutput("wrData", 16'(databus), 16'(expData));
            end
            default: checkOutput("busIdle", 16'(databus), 16'h00FF);
        endcase
        checkOutput("lastRx", 16'(last_rx), 16'(expLastRx));
        checkOutput("echoCnt", 16'(echo_cnt), 16'(expCnt));
        checkOutput("iocsRepeat", 16'(prevIocs && iocs && (ioaddr == prevAddr)), 16'h0000);
        prevIocs = iocs;
        prevAddr = ioaddr;
    end

    initial begin
        bit sawAccess;

        applyStimulus(1'b0, 1'b1, 2'b01, 8'h00);
        repeat (3) @(negedge clk);
        checkOutput("rstIocs", 16'(iocs), 16'h0000);
        checkOutput("rstIorw", 16'(iorw), 16'h0001);
        checkOutput("rstAddr", 16'(ioaddr), 16'h0000);
        checkOutput("rstBus", 16'(databus), 16'h00FF);
        checkOutput("rstLastRx", 16'(last_rx), 16'h0000);
        checkOutput("rstCnt", 16'(echo_cnt), 16'h0000);

        rst = 1'b1;
        @(negedge clk);
        checkOutput("cfg01LoCs", 16'(iocs), 16'h0001);
        checkOutput("cfg01LoAddr", 16'(ioaddr), 16'h0002);
        checkOutput("cfg01LoData", 16'(databus), 16'h008B);
        @(negedge clk);
        checkOutput("cfg01HiAddr", 16'(ioaddr), 16'h0003);
        checkOutput("cfg01HiData", 16'(databus), 16'h0002);
        @(negedge clk);
        checkOutput("idleCs", 16'(iocs), 16'h0000);
        checkOutput("idleBus", 16'(databus), 16'h00FF);

        // First echo at minimum latency
        applyStimulus(1'b1, 1'b1, 2'b01, 8'h41);
        waitAccess(1'b1, "read41");
        checkOutput("read41Addr", 16'(ioaddr), 16'h0000);
        rda = 1'b0;
        @(negedge clk);
        checkOutput("read41LastRx", 16'(last_rx), 16'h0041);
        checkOutput("waitCs", 16'(iocs), 16'h0000);
        @(negedge clk);
        checkOutput("write41Cs", 16'(iocs), 16'h0001);
        checkOutput("write41Iorw", 16'(iorw), 16'h0000);
        checkOutput("write41Data", 16'(databus), 16'h0041);
        checkOutput("write41Cnt", 16'(echo_cnt), 16'h0001);

        // Transmit buffer busy for 20 cycles
        applyStimulus(1'b1, 1'b0, 2'b01, 8'h5A);
        waitAccess(1'b1, "read5A");
        rda = 1'b0;
        sawAccess = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (iocs !== 1'b0) sawAccess = 1'b1;
        end
        checkOutput("holdNoAccess", 16'(sawAccess), 16'h0000);
        checkOutput("holdLastRx", 16'(last_rx), 16'h005A);
        tbr = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("write5ACs", 16'(iocs), 16'h0001);
        checkOutput("write5AData", 16'(databus), 16'h005A);
        checkOutput("write5ACnt", 16'(echo_cnt), 16'h0002);

        // Baud change during WAIT_TBR is deferred until the echo completes
        applyStimulus(1'b1, 1'b0, 2'b01, 8'h33);
        waitAccess(1'b1, "read33");
        rda = 1'b0;
        br_cfg = 2'b11;
        repeat (3) @(negedge clk);
        tbr = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("write33Data", 16'(databus), 16'h0033);
        checkOutput("write33Cnt", 16'(echo_cnt), 16'h0003);
        @(negedge clk);
        checkOutput("gapCs", 16'(iocs), 16'h0000);
        @(negedge clk);
        checkOutput("cfg11LoAddr", 16'(ioaddr), 16'h0002);
        checkOutput("cfg11LoData", 16'(databus), 16'h00A3);
        @(negedge clk);
        checkOutput("cfg11HiAddr", 16'(ioaddr), 16'h0003);
        checkOutput("cfg11HiData", 16'(databus), 16'h0000);

        // Baud change and rda together: reprogram first, then the read
        applyStimulus(1'b1, 1'b1, 2'b00, 8'h77);
        @(negedge clk);
        checkOutput("bothIdleCs", 16'(iocs), 16'h0000);
        @(negedge clk);
        checkOutput("cfg00LoAddr", 16'(ioaddr), 16'h0002);
        checkOutput("cfg00LoData", 16'(databus), 16'h0016);
        @(negedge clk);
        checkOutput("cfg00HiData", 16'(databus), 16'h0005);
        @(negedge clk);
        checkOutput("bothIdle2Cs", 16'(iocs), 16'h0000);
        @(negedge clk);
        checkOutput("bothReadCs", 16'(iocs), 16'h0001);
        checkOutput("bothReadIorw", 16'(iorw), 16'h0001);
        rda = 1'b0;
        waitAccess(1'b0, "write77");
        checkOutput("write77Data", 16'(databus), 16'h0077);
        checkOutput("write77Cnt", 16'(echo_cnt), 16'h0004);

        // Run the counter round to zero
        for (int i = 0; i < 252; i++) begin
            doEcho(8'(i) ^ 8'hC3);
            if (i == 250) checkOutput("cntFF", 16'(echo_cnt), 16'h00FF);
        end
        checkOutput("cntWrap", 16'(echo_cnt), 16'h0000);
        checkOutput("wrapLastRx", 16'(last_rx), 16'h0038);

        // Reset in the middle of a write
        applyStimulus(1'b1, 1'b1, 2'b00, 8'h99);
        waitAccess(1'b1, "read99");
        rda = 1'b0;
        waitAccess(1'b0, "write99");
        #2 rst = 1'b0;
        #1;
        checkOutput("midRstCs", 16'(iocs), 16'h0000);
        checkOutput("midRstBus", 16'(databus), 16'h00FF);
        checkOutput("midRstCnt", 16'(echo_cnt), 16'h0000);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("restartCs", 16'(iocs), 16'h0001);
        checkOutput("restartAddr", 16'(ioaddr), 16'h0002);
        checkOutput("restartData", 16'(databus), 16'h0016);
        @(negedge clk);
        checkOutput("restartHiData", 16'(databus), 16'h0005);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
